perf_monitor: RTL and testbench
===============================

PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of every counter.
REQ-002 SHALL have parameter NUM_EVT, default 4: number of generic event counters (1..16).
REQ-003 SHALL have parameter RET_LANES, default 1: retire lanes summed per cycle (1..4).
REQ-004 SHALL have parameter WARMUP, default 2: cycles after reset release that are not counted.
REQ-005 SHALL have parameter PASS_ADR, default 100: store address signalling test completion.
REQ-006 SHALL have parameter PASS_DATA, default 25: store data required for a pass.
REQ-007 SHALL have parameter IGNORE_ADR, default 96: store address never treated as a failure.
REQ-008 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-009 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-010 SHALL have port clear_i  input  1: synchronous clear of counters and status.
REQ-011 SHALL have port retire_i  input  RET_LANES: one bit per instruction retired this cycle.
REQ-012 SHALL have port evt_i  input  NUM_EVT: per-event increment strobes (stall, flush, ...).
REQ-013 SHALL have ports MemWriteM, DataAdrM, WriteDataM  input  1/32/32: memory-stage store observed.
REQ-014 SHALL have port rd_sel_i  input  $clog2(NUM_EVT+2): readout select.
REQ-015 SHALL have port rd_data_o  output  CNT_W: 0 = cycles, 1 = retired, 2+k = evt k; out-of-range selects read 0.
REQ-016 SHALL have ports done_o, pass_o, fail_o  output  1: completion status.
REQ-017 SHALL have ports fail_adr_o, fail_data_o  output  32/32: first offending store.

Function
REQ-018 SHALL implement states WARM, RUN, PASS, FAIL; WARM is entered on reset or clear_i.
REQ-019 SHALL count WARMUP cycles in WARM, then enter RUN; WARMUP=0 enters RUN on the first cycle.
REQ-020 SHALL, in RUN, increment the cycle counter by 1 every cycle.
REQ-021 SHALL, in RUN, add the popcount of retire_i (0..RET_LANES) to the retired counter in one cycle.
REQ-022 SHALL, in RUN, increment event counter k when evt_i[k]=1; all counters update concurrently.
REQ-023 SHALL, in RUN, enter PASS when MemWriteM=1, DataAdrM==PASS_ADR and WriteDataM==PASS_DATA; the pass cycle itself is counted.
REQ-024 SHALL, in RUN, enter FAIL when MemWriteM=1, DataAdrM!=PASS_ADR and DataAdrM!=IGNORE_ADR, capturing address/data in that cycle.
REQ-025 SHALL enter FAIL on a store to PASS_ADR with data != PASS_DATA.
REQ-026 SHALL ignore all stores in WARM, PASS and FAIL.
REQ-027 SHALL freeze all counters in WARM, PASS and FAIL.
REQ-028 SHALL drive done_o=1 in PASS or FAIL, pass_o=1 only in PASS, fail_o=1 only in FAIL, all registered (visible one cycle after the terminating store).
REQ-029 SHALL give clear_i priority over every other event in the same cycle.
REQ-030 SHALL drive rd_data_o combinationally from the selected counter.

Reset
REQ-031 SHALL on reset set state WARM, warm-up count 0, all counters 0, done_o/pass_o/fail_o 0, fail_adr_o/fail_data_o 0.
REQ-032 SHALL abort any in-progress run on reset asserted mid-operation, with no partial counter update.

Configuration
REQ-033 SHALL, with PERF_SAT_EN defined, saturate every counter at 2^CNT_W-1 (a multi-lane add that would overflow clamps to the maximum).
REQ-034 SHALL, without PERF_SAT_EN, let every counter wrap modulo 2^CNT_W.

Verification
REQ-035 SHALL verify: reset released, WARMUP=2, 10 idle cycles then store (100,25) -> pass_o=1, cycles=9 (10 cycles minus 2 warm-up, plus pass cycle), done_o=1.
REQ-036 SHALL verify: RET_LANES=2, retire_i=2'b11 for 5 cycles then store (100,25) -> retired=10.
REQ-037 SHALL verify: store (96,7) then store (100,25) -> no fail, pass_o=1; store (44,3) -> fail_o=1, fail_adr_o=44, fail_data_o=3, counters frozen.
REQ-038 SHALL verify: CNT_W=4, evt_i[0]=1 for 20 RUN cycles -> evt0=15 with PERF_SAT_EN, evt0=4 without.
REQ-039 SHALL verify: clear_i and pass store in the same cycle -> state WARM, all counters 0, pass_o=0.
REQ-040 SHALL verify: reset asserted mid-RUN asynchronously -> all outputs 0 before the next rising clk edge.

Source files
------------

// File: rtl/perf_monitor.sv
`timescale 1ns/1ps
// Performance monitor: cycle/retire/event counters gated by a WARM/RUN/PASS/FAIL
// run tracker driven by memory-stage stores. Define PERF_SAT_EN for saturating counters.
module perf_monitor #(
  parameter int          CNT_W      = 32,
  parameter int          NUM_EVT    = 4,
  parameter int          RET_LANES  = 1,
  parameter int          WARMUP     = 2,
  parameter logic [31:0] PASS_ADR   = 32'd100,
  parameter logic [31:0] PASS_DATA  = 32'd25,
  parameter logic [31:0] IGNORE_ADR = 32'd96,
  localparam int         SEL_W      = $clog2(NUM_EVT + 2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic [RET_LANES-1:0] retire_i,
  input  logic [NUM_EVT-1:0]   evt_i,
  input  logic                 MemWriteM,
  input  logic [31:0]          DataAdrM,
  input  logic [31:0]          WriteDataM,
  input  logic [SEL_W-1:0]     rd_sel_i,
  output logic [CNT_W-1:0]     rd_data_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic [31:0]          fail_adr_o,
  output logic [31:0]          fail_data_o,
  output logic [1:0]           dbg_state_o
);

  localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  typedef enum logic [1:0] {ST_WARM, ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t              state_q, state_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic [CNT_W-1:0]    evt_q [NUM_EVT];
  logic [CNT_W-1:0]    evt_d [NUM_EVT];
  logic [31:0]         fail_adr_q, fail_adr_d;
  logic [31:0]         fail_data_q, fail_data_d;

  logic       warm_done;
  logic       run_active;
  logic       pass_hit;
  logic       fail_hit;
  logic [2:0] ret_cnt;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic [2:0] inc);
`ifdef PERF_SAT_EN
    logic [CNT_W+3:0] s;
    s = (CNT_W+4)'(v) + (CNT_W+4)'(inc);
    if (s > (CNT_W+4)'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
`else
    return v + CNT_W'(inc);
`endif
  endfunction

  // With WARMUP=0 the WARM state already behaves as RUN so the first cycle counts.
  assign warm_done  = (WARMUP == 0) || (warm_q == WARM_W'(WARMUP - 1));
  assign run_active = (state_q == ST_RUN) || ((WARMUP == 0) && (state_q == ST_WARM));
  assign pass_hit   = MemWriteM && (DataAdrM == PASS_ADR) && (WriteDataM == PASS_DATA);
  assign fail_hit   = MemWriteM && !pass_hit && (DataAdrM != IGNORE_ADR);

  always_comb begin
    ret_cnt = '0;
    for (int i = 0; i < RET_LANES; i++) ret_cnt = ret_cnt + 3'(retire_i[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WARM;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    if (state_q == ST_WARM) begin
      if (warm_done) state_d = ST_RUN;
      else           warm_d  = warm_q + 1'b1;
    end
    if (run_active) begin
      if (pass_hit)      state_d = ST_PASS;
      else if (fail_hit) state_d = ST_FAIL;
    end
    if (clear_i) begin
      state_d = ST_WARM;
      warm_d  = '0;
    end
  end

  always_comb begin
    done_o      = (state_q == ST_PASS) || (state_q == ST_FAIL);
    pass_o      = (state_q == ST_PASS);
    fail_o      = (state_q == ST_FAIL);
    dbg_state_o = state_q;
  end

  always_comb begin
    cyc_d       = cyc_q;
    ret_d       = ret_q;
    evt_d       = evt_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;
    if (run_active) begin
      cyc_d = bump(cyc_q, 3'd1);
      ret_d = bump(ret_q, ret_cnt);
      for (int k = 0; k < NUM_EVT; k++) evt_d[k] = bump(evt_q[k], {2'b00, evt_i[k]});
      if (fail_hit) begin
        fail_adr_d  = DataAdrM;
        fail_data_d = WriteDataM;
      end
    end
    if (clear_i) begin
      cyc_d       = '0;
      ret_d       = '0;
      fail_adr_d  = '0;
      fail_data_d = '0;
      for (int k = 0; k < NUM_EVT; k++) evt_d[k] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q       <= '0;
      ret_q       <= '0;
      fail_adr_q  <= '0;
      fail_data_q <= '0;
      for (int k = 0; k < NUM_EVT; k++) evt_q[k] <= '0;
    end else begin
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
      for (int k = 0; k < NUM_EVT; k++) evt_q[k] <= evt_d[k];
    end
  end

  assign fail_adr_o  = fail_adr_q;
  assign fail_data_o = fail_data_q;

  always_comb begin
    rd_data_o = '0;
    if (rd_sel_i == SEL_W'(0)) rd_data_o = cyc_q;
    if (rd_sel_i == SEL_W'(1)) rd_data_o = ret_q;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k + 2)) rd_data_o = evt_q[k];
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
`timescale 1ns/1ps
// Bench for perf_monitor: a 32-bit and a 4-bit instance share stimulus and are
// compared against an unbounded-count reference model plus directed vectors.
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  retire = '0;
  logic [3:0]  evt = '0;
  logic        mem_we = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  rd_sel = '0;

  logic [31:0] rd_a, fadr_a, fdata_a;
  logic        done_a, pass_a, fail_a;
  logic [1:0]  st_a;
  logic [3:0]  rd_b;
  logic [31:0] fadr_b, fdata_b;
  logic        done_b, pass_b, fail_b;
  logic [1:0]  st_b;

  perf_monitor #(.CNT_W(32), .NUM_EVT(4), .RET_LANES(2), .WARMUP(2)) u_dut_a (
    .clk(clk), .reset(reset), .clear_i(clear), .retire_i(retire), .evt_i(evt),
    .MemWriteM(mem_we), .DataAdrM(adr), .WriteDataM(wdata), .rd_sel_i(rd_sel),
    .rd_data_o(rd_a), .done_o(done_a), .pass_o(pass_a), .fail_o(fail_a),
    .fail_adr_o(fadr_a), .fail_data_o(fdata_a), .dbg_state_o(st_a));

  perf_monitor #(.CNT_W(4), .NUM_EVT(4), .RET_LANES(2), .WARMUP(2)) u_dut_b (
    .clk(clk), .reset(reset), .clear_i(clear), .retire_i(retire), .evt_i(evt),
    .MemWriteM(mem_we), .DataAdrM(adr), .WriteDataM(wdata), .rd_sel_i(rd_sel),
    .rd_data_o(rd_b), .done_o(done_b), .pass_o(pass_b), .fail_o(fail_b),
    .fail_adr_o(fadr_b), .fail_data_o(fdata_b), .dbg_state_o(st_b));

  // clock / reset
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: true (unbounded) counts, each output view derived from them
  localparam int M_WARM = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;
  longint      m_cnt [6];
  int          m_phase;
  int          m_warm;
  logic [31:0] m_fadr, m_fdata;

  typedef struct {
    logic        clr;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  ret;
    logic [3:0]  ev;
    logic        e_done;
    logic        e_pass;
    logic        e_fail;
    logic [31:0] e_fadr;
    logic [31:0] e_fdata;
  } vec_t;
  vec_t vecs [16];

  function automatic vec_t mk(input logic clr, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] ret, input logic [3:0] ev,
                              input logic e_done, input logic e_pass, input logic e_fail,
                              input logic [31:0] e_fadr, input logic [31:0] e_fdata);
    vec_t v;
    v.clr = clr; v.we = we; v.a = a; v.d = d; v.ret = ret; v.ev = ev;
    v.e_done = e_done; v.e_pass = e_pass; v.e_fail = e_fail;
    v.e_fadr = e_fadr; v.e_fdata = e_fdata;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint exp_a(input int sel);
    longint v;
    v = (sel < 6) ? m_cnt[sel] : 64'd0;
    return v & 64'hFFFF_FFFF;
  endfunction

  function automatic longint exp_b(input int sel);
    longint v;
    v = (sel < 6) ? m_cnt[sel] : 64'd0;
`ifdef PERF_SAT_EN
    return (v > 15) ? 64'd15 : v;
`else
    return v % 16;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_cnt[i] = 0;
    m_phase = M_WARM;
    m_warm  = 0;
    m_fadr  = '0;
    m_fdata = '0;
  endtask

  task automatic model_fail();
    m_phase = M_FAIL;
    m_fadr  = adr;
    m_fdata = wdata;
  endtask

  task automatic model_step();
    if (clear) begin
      model_reset();
    end else if (m_phase == M_WARM) begin
      m_warm++;
      if (m_warm >= 2) m_phase = M_RUN;
    end else if (m_phase == M_RUN) begin
      m_cnt[0] += 1;
      m_cnt[1] += $countones(retire);
      for (int k = 0; k < 4; k++) m_cnt[2+k] += evt[k];
      if (mem_we) begin
        if (adr == 32'd100) begin
          if (wdata == 32'd25) m_phase = M_PASS;
          else model_fail();
        end else if (adr != 32'd96) begin
          model_fail();
        end
      end
    end
  endtask

  // driver tasks
  task automatic set_idle();
    clear = 1'b0; mem_we = 1'b0; retire = '0; evt = '0; adr = '0; wdata = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1; adr = a; wdata = d;
  endtask

  task automatic check_status();
    check("done_a", done_a, m_phase >= M_PASS);
    check("pass_a", pass_a, m_phase == M_PASS);
    check("fail_a", fail_a, m_phase == M_FAIL);
    check("fadr_a", fadr_a, m_fadr);
    check("fdata_a", fdata_a, m_fdata);
    check("done_b", done_b, m_phase >= M_PASS);
    check("fail_b", fail_b, m_phase == M_FAIL);
    check("fadr_b", fadr_b, m_fadr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_status();
    check($sformatf("rd_a_sel%0d", rd_sel), rd_a, exp_a(int'(rd_sel)));
    check($sformatf("rd_b_sel%0d", rd_sel), rd_b, exp_b(int'(rd_sel)));
  endtask

  task automatic check_counters();
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      check($sformatf("cnt_a_sel%0d", s), rd_a, exp_a(s));
      check($sformatf("cnt_b_sel%0d", s), rd_b, exp_b(s));
    end
  endtask

  task automatic restart();
    set_idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 1'b0, 32'd0,   32'd0,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
    vecs[1]  = mk(1'b0, 1'b1, 32'd44,  32'd3,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
    vecs[2]  = mk(1'b0, 1'b0, 32'd0,   32'd0,  2'd1, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
    vecs[3]  = mk(1'b0, 1'b1, 32'd96,  32'd7,  2'd3, 4'h1, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
    vecs[4]  = mk(1'b0, 1'b1, 32'd100, 32'd25, 2'd2, 4'h2, 1'b1, 1'b1, 1'b0, 32'd0,   32'd0);
    vecs[5]  = mk(1'b0, 1'b1, 32'd44,  32'd3,  2'd3, 4'hf, 1'b1, 1'b1, 1'b0, 32'd0,   32'd0);
    vecs[6]  = mk(1'b1, 1'b0, 32'd0,   32'd0,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
    vecs[7]  = mk(1'b0, 1'b0, 32'd0,   32'd0,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
    vecs[8]  = mk(1'b0, 1'b0, 32'd0,   32'd0,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
    vecs[9]  = mk(1'b0, 1'b1, 32'd100, 32'd24, 2'd1, 4'h4, 1'b1, 1'b0, 1'b1, 32'd100, 32'd24);
    vecs[10] = mk(1'b0, 1'b1, 32'd44,  32'd3,  2'd0, 4'h0, 1'b1, 1'b0, 1'b1, 32'd100, 32'd24);
    vecs[11] = mk(1'b1, 1'b0, 32'd0,   32'd0,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
    vecs[12] = mk(1'b0, 1'b0, 32'd0,   32'd0,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
    vecs[13] = mk(1'b0, 1'b0, 32'd0,   32'd0,  2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0,   32'd0);
    vecs[14] = mk(1'b0, 1'b1, 32'd44,  32'd3,  2'd3, 4'hf, 1'b1, 1'b0, 1'b1, 32'd44,  32'd3);
    vecs[15] = mk(1'b0, 1'b0, 32'd0,   32'd0,  2'd3, 4'hf, 1'b1, 1'b0, 1'b1, 32'd44,  32'd3);

    // reset values, checked while reset is still held
    model_reset();
    #1 reset = 1'b1;
    #2;
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_fail", fail_a, 0);
    check("rst_fadr", fadr_a, 0);
    check("rst_fdata", fdata_a, 0);
    check_counters();
    @(posedge clk);
    #5 reset = 1'b0;

    // 10 idle cycles then the pass store: 8 run cycles + pass cycle
    rd_sel = 3'd0;
    repeat (10) tick();
    store(32'd100, 32'd25);
    tick();
    set_idle();
    check("pass_done", done_a, 1);
    check("pass_pass", pass_a, 1);
    check("pass_cycles", rd_a, 9);

    // two retire lanes for five cycles
    restart();
    retire = 2'b11;
    repeat (5) tick();
    retire = 2'b00;
    store(32'd100, 32'd25);
    tick();
    set_idle();
    rd_sel = 3'd1;
    #1 check("two_lane_retired", rd_a, 10);
    check_counters();

    // directed store/clear vectors
    for (int i = 0; i < 16; i++) begin
      clear = vecs[i].clr; mem_we = vecs[i].we; adr = vecs[i].a; wdata = vecs[i].d;
      retire = vecs[i].ret; evt = vecs[i].ev;
      rd_sel = 3'(i % 8);
      tick();
      check($sformatf("vec%0d_done", i), done_a, vecs[i].e_done);
      check($sformatf("vec%0d_pass", i), pass_a, vecs[i].e_pass);
      check($sformatf("vec%0d_fail", i), fail_a, vecs[i].e_fail);
      check($sformatf("vec%0d_fadr", i), fadr_a, vecs[i].e_fadr);
      check($sformatf("vec%0d_fdata", i), fdata_a, vecs[i].e_fdata);
    end
    set_idle();
    check_counters();

    // 4-bit counter overflow under 20 event cycles
    restart();
    evt = 4'h1;
    repeat (20) tick();
    evt = 4'h0;
    rd_sel = 3'd2;
`ifdef PERF_SAT_EN
    #1 check("narrow_evt0", rd_b, 15);
`else
    #1 check("narrow_evt0", rd_b, 4);
`endif
    check_counters();

    // clear wins over a pass store in the same cycle
    retire = 2'b01;
    repeat (3) tick();
    clear = 1'b1;
    store(32'd100, 32'd25);
    tick();
    set_idle();
    check("clr_pass", pass_a, 0);
    check("clr_done", done_a, 0);
    rd_sel = 3'd0;
    #1 check("clr_cycles", rd_a, 0);
    check_counters();

    // randomized traffic
    for (int it = 0; it < 900; it++) begin
      set_idle();
      clear  = ($urandom_range(0, 59) == 0) || ((m_phase >= M_PASS) && ($urandom_range(0, 5) == 0));
      retire = 2'($urandom_range(0, 3));
      evt    = 4'($urandom_range(0, 15));
      rd_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0:       adr = 32'd100;
          1:       adr = 32'd96;
          2:       adr = 32'd44;
          default: adr = $urandom;
        endcase
        wdata  = ($urandom_range(0, 1) == 0) ? 32'd25 : 32'($urandom_range(0, 40));
        mem_we = 1'b1;
      end
      tick();
      if (it % 50 == 49) check_counters();
    end

    // asynchronous reset in the middle of a run that has already failed
    restart();
    retire = 2'b11;
    evt    = 4'hf;
    repeat (4) tick();
    store(32'd44, 32'd3);
    tick();
    set_idle();
    check("pre_rst_fail", fail_a, 1);
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_done", done_a, 0);
    check("arst_fail", fail_a, 0);
    check("arst_fadr", fadr_a, 0);
    check("arst_fdata", fdata_a, 0);
    check("arst_fail_b", fail_b, 0);
    check_counters();
    @(posedge clk);
    #5 reset = 1'b0;
    repeat (4) tick();
    check_counters();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
